pv2ooo_muldiv_issue_unit: RTL and testbench

//  Initiator-side front end of the pipelined muldiv unit for the pv2ooo core.
//  It accepts muldiv ops from the issue stage and drives the muldiv request

---
 rtl/pv2ooo_muldiv_issue_unit_if.sv | 58 +++++
 rtl/pv2ooo_muldiv_issue_unit.sv | 106 ++++++++++
 tb/tb_pv2ooo_muldiv_issue_unit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pv2ooo_muldiv_issue_unit_if.sv
// Bundle of the issue, muldiv request/response and writeback handshakes
// seen by the pv2ooo muldiv issue unit. The master view belongs to the unit,
// and the slave view belongs to its surroundings (issue stage, muldiv unit, writeback).
interface pv2ooo_muldiv_issue_unit_if #(
  parameter int TAG_W = 5,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             issue_val;
  logic             issue_rdy;
  logic [2:0]       issue_fn;
  logic [31:0]      issue_a;
  logic [31:0]      issue_b;
  logic [TAG_W-1:0] issue_tag;

  logic [2:0]       muldivreq_msg_fn;
  logic [31:0]      muldivreq_msg_a;
  logic [31:0]      muldivreq_msg_b;
  logic             muldivreq_val;
  logic             muldivreq_rdy;

  logic [63:0]      muldivresp_msg_result;
  logic             muldivresp_val;
  logic             muldivresp_rdy;

  logic             wb_val;
  logic             wb_rdy;
  logic [TAG_W-1:0] wb_tag;
  logic [31:0]      wb_data;

  logic [CNT_W-1:0] inflight_count;
  logic             proto_err;

  modport master (
    input  issue_val, issue_fn, issue_a, issue_b, issue_tag,
    output issue_rdy,
    output muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b, muldivreq_val,
    input  muldivreq_rdy,
    input  muldivresp_msg_result, muldivresp_val,
    output muldivresp_rdy,
    output wb_val, wb_tag, wb_data,
    input  wb_rdy,
    output inflight_count, proto_err
  );

  modport slave (
    output issue_val, issue_fn, issue_a, issue_b, issue_tag,
    input  issue_rdy,
    input  muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b, muldivreq_val,
    output muldivreq_rdy,
    output muldivresp_msg_result, muldivresp_val,
    input  muldivresp_rdy,
    input  wb_val, wb_tag, wb_data,
    output wb_rdy,
    input  inflight_count, proto_err
  );
endinterface

// File: rtl/pv2ooo_muldiv_issue_unit.sv
// Front end of the pipelined muldiv unit. Ops are forwarded to the muldiv
// request port combinationally, and each op's tag and result-half select are
// queued in order. Every response is paired with the oldest queued entry and
// written into a one-entry registered writeback stage.
module pv2ooo_muldiv_issue_unit #(
  parameter int TAG_W = 5,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  pv2ooo_muldiv_issue_unit_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic             sel_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             wb_val_q;
  logic [TAG_W-1:0] wb_tag_q;
  logic [31:0]      wb_data_q;
  logic             proto_err_q;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic resp_fire;
  logic sel_hi;

  // Flow control depends only on the registered count, so a pop at full
  // cannot reopen issue_rdy within the same cycle.
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign sel_hi    = (bus.issue_fn == 3'd3) || (bus.issue_fn == 3'd4);

  assign bus.issue_rdy        = bus.muldivreq_rdy && !full;
  assign bus.muldivreq_val    = bus.issue_val && !full;
  assign bus.muldivreq_msg_fn = bus.issue_fn;
  assign bus.muldivreq_msg_a  = bus.issue_a;
  assign bus.muldivreq_msg_b  = bus.issue_b;

  assign bus.muldivresp_rdy = !wb_val_q || bus.wb_rdy;

  assign push      = bus.issue_val && bus.issue_rdy;
  assign resp_fire = bus.muldivresp_val && bus.muldivresp_rdy;
  assign pop       = resp_fire && !empty;

  assign bus.wb_val         = wb_val_q;
  assign bus.wb_tag         = wb_tag_q;
  assign bus.wb_data        = wb_data_q;
  assign bus.inflight_count = count;
  assign bus.proto_err      = proto_err_q;

  // Tag FIFO storage: written on each accepted op; contents need no reset
  // because the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= bus.issue_tag;
      sel_mem[wr_ptr] <= sel_hi;
    end
  end

  // FIFO pointers and in-flight count; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Writeback register: load on a paired response, otherwise drain when the
  // consumer takes the entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_val_q  <= 1'b0;
      wb_tag_q  <= '0;
      wb_data_q <= '0;
    end else if (pop) begin
      wb_val_q  <= 1'b1;
      wb_tag_q  <= tag_mem[rd_ptr];
      wb_data_q <= sel_mem[rd_ptr] ? bus.muldivresp_msg_result[63:32]
                                   : bus.muldivresp_msg_result[31:0];
    end else if (wb_val_q && bus.wb_rdy) begin
      wb_val_q  <= 1'b0;
    end
  end

  // Sticky protocol error: a response accepted while nothing was in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proto_err_q <= 1'b0;
    end else if (resp_fire && empty) begin
      proto_err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pv2ooo_muldiv_issue_unit.sv
// Testbench for pv2ooo_muldiv_issue_unit: a table of directed muldiv vectors
// with hand-computed responses, plus hand-written multi-cycle sequences for
// full, backpressure, protocol error, async reset and random handshakes.
module tb_pv2ooo_muldiv_issue_unit;
  logic clk;
  logic reset;

  pv2ooo_muldiv_issue_unit_if #(.TAG_W(5), .DEPTH(4)) bus ();

  pv2ooo_muldiv_issue_unit #(.TAG_W(5), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [63:0] resp;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];
  int   checks;
  int   errors;

  // Free-running clock: posedges at 5,15,...; the bench acts on negedges.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input bit chk_fwd);
    bit done;
    done = 0;
    bus.issue_val = 1'b1;
    bus.issue_fn  = fn;
    bus.issue_a   = a;
    bus.issue_b   = b;
    bus.issue_tag = tag;
    for (int w = 0; w < 40 && !done; w++) begin
      #1;
      done = bus.issue_rdy;
      if (done && chk_fwd) begin
        check_output("req_val", 64'(bus.muldivreq_val), 64'd1);
        check_output("req_fn",  64'(bus.muldivreq_msg_fn), 64'(fn));
        check_output("req_a",   64'(bus.muldivreq_msg_a), 64'(a));
        check_output("req_b",   64'(bus.muldivreq_msg_b), 64'(b));
      end
      @(negedge clk);
    end
    if (!done) check_output("issue_timeout", 64'd0, 64'd1);
    bus.issue_val = 1'b0;
  endtask

  task automatic send_resp(input logic [63:0] result);
    bit done;
    done = 0;
    bus.muldivresp_val        = 1'b1;
    bus.muldivresp_msg_result = result;
    for (int w = 0; w < 40 && !done; w++) begin
      #1;
      done = bus.muldivresp_rdy;
      @(negedge clk);
    end
    if (!done) check_output("resp_timeout", 64'd0, 64'd1);
    bus.muldivresp_val = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    issue_op(v.fn, v.a, v.b, v.tag, 1'b1);
    check_output("vec_count", 64'(bus.inflight_count), 64'd1);
    check_output("vec_wb_idle", 64'(bus.wb_val), 64'd0);
    send_resp(v.resp);
    check_output("vec_wb_val",  64'(bus.wb_val), 64'd1);
    check_output("vec_wb_tag",  64'(bus.wb_tag), 64'(v.tag));
    check_output("vec_wb_data", 64'(bus.wb_data), 64'(v.exp));
    @(negedge clk);
    check_output("vec_wb_drain", 64'(bus.wb_val), 64'd0);
    check_output("vec_count0", 64'(bus.inflight_count), 64'd0);
  endtask

  initial begin
    logic [36:0] e;
    logic [36:0] expq [$];
    logic [63:0] respq [$];
    bit ifire, rfire;
    int idx, got;

    checks = 0;
    errors = 0;

    vecs[0]  = '{3'd0, 32'hfffffff8, 32'h00000008, 5'd3,  64'hffffffff_ffffffc0, 32'hffffffc0};
    vecs[1]  = '{3'd3, 32'h00000222, 32'h00000032, 5'd7,  64'h0000002e_0000000a, 32'h0000002e};
    vecs[2]  = '{3'd1, 32'h00000222, 32'h00000032, 5'd7,  64'h0000002e_0000000a, 32'h0000000a};
    vecs[3]  = '{3'd2, 32'hdeadbeef, 32'h0000beef, 5'd9,  64'h0000227f_00012a90, 32'h00012a90};
    vecs[4]  = '{3'd4, 32'hdeadbeef, 32'h0000beef, 5'd10, 64'h0000227f_00012a90, 32'h0000227f};
    vecs[5]  = '{3'd0, 32'h00010000, 32'h00010000, 5'd11, 64'h00000001_00000000, 32'h00000000};
    vecs[6]  = '{3'd5, 32'h00000001, 32'h00000002, 5'd12, 64'h12345678_9abcdef0, 32'h9abcdef0};
    vecs[7]  = '{3'd7, 32'h00000003, 32'h00000004, 5'd13, 64'haaaaaaaa_55555555, 32'h55555555};
    vecs[8]  = '{3'd1, 32'hfffffff9, 32'h00000002, 5'd14, 64'hffffffff_fffffffd, 32'hfffffffd};
    vecs[9]  = '{3'd3, 32'hfffffff9, 32'h00000002, 5'd15, 64'hffffffff_fffffffd, 32'hffffffff};
    vecs[10] = '{3'd2, 32'h00000064, 32'h00000007, 5'd16, 64'h00000002_0000000e, 32'h0000000e};
    vecs[11] = '{3'd4, 32'h00000064, 32'h00000007, 5'd31, 64'h00000002_0000000e, 32'h00000002};

    reset                     = 1'b1;
    bus.issue_val             = 1'b0;
    bus.issue_fn              = 3'd0;
    bus.issue_a               = 32'd0;
    bus.issue_b               = 32'd0;
    bus.issue_tag             = 5'd0;
    bus.muldivreq_rdy         = 1'b1;
    bus.muldivresp_val        = 1'b0;
    bus.muldivresp_msg_result = 64'd0;
    bus.wb_rdy                = 1'b1;

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("rst_wb_val",    64'(bus.wb_val), 64'd0);
    check_output("rst_wb_tag",    64'(bus.wb_tag), 64'd0);
    check_output("rst_wb_data",   64'(bus.wb_data), 64'd0);
    check_output("rst_count",     64'(bus.inflight_count), 64'd0);
    check_output("rst_proto_err", 64'(bus.proto_err), 64'd0);
    check_output("rst_issue_rdy", 64'(bus.issue_rdy), 64'd1);
    @(negedge clk);

    // Directed table, one op at a time
    for (int i = 0; i < 12; i++) apply_stimulus(vecs[i]);

    // Fill the FIFO, confirm it stalls, and that one pop reopens next cycle
    for (int t = 1; t <= 4; t++) issue_op(3'd0, 32'(t), 32'd1, 5'(t), 1'b0);
    check_output("full_count", 64'(bus.inflight_count), 64'd4);
    bus.issue_val = 1'b1;
    bus.issue_tag = 5'd5;
    #1;
    check_output("full_issue_rdy", 64'(bus.issue_rdy), 64'd0);
    check_output("full_req_val",   64'(bus.muldivreq_val), 64'd0);
    bus.muldivresp_val        = 1'b1;
    bus.muldivresp_msg_result = 64'h0_00000011;
    #1;
    check_output("full_pop_rdy", 64'(bus.issue_rdy), 64'd0);
    @(negedge clk);
    bus.issue_val      = 1'b0;
    bus.muldivresp_val = 1'b0;
    #1;
    check_output("full_reopen",  64'(bus.issue_rdy), 64'd1);
    check_output("full_count3",  64'(bus.inflight_count), 64'd3);
    check_output("full_wb_tag1", 64'(bus.wb_tag), 64'd1);
    check_output("full_wb_dat1", 64'(bus.wb_data), 64'h11);
    @(negedge clk);
    for (int t = 2; t <= 4; t++) begin
      send_resp({32'd0, 32'(t * 16 + 1)});
      check_output("full_wb_tag", 64'(bus.wb_tag), 64'(t));
      check_output("full_wb_dat", 64'(bus.wb_data), 64'(t * 16 + 1));
    end
    @(negedge clk);
    check_output("full_count0", 64'(bus.inflight_count), 64'd0);

    // Writeback backpressure holds the entry and blocks the next response
    bus.wb_rdy = 1'b0;
    issue_op(3'd0, 32'd5, 32'd6, 5'd1, 1'b0);
    issue_op(3'd3, 32'd7, 32'd8, 5'd2, 1'b0);
    send_resp(64'h00000000_000000a1);
    bus.muldivresp_val        = 1'b1;
    bus.muldivresp_msg_result = 64'h000000b2_00000000;
    #1;
    check_output("bp_resp_rdy", 64'(bus.muldivresp_rdy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    check_output("bp_hold_val",  64'(bus.wb_val), 64'd1);
    check_output("bp_hold_tag",  64'(bus.wb_tag), 64'd1);
    check_output("bp_hold_data", 64'(bus.wb_data), 64'ha1);
    check_output("bp_count",     64'(bus.inflight_count), 64'd1);
    bus.wb_rdy = 1'b1;
    #1;
    check_output("bp_resp_rdy1", 64'(bus.muldivresp_rdy), 64'd1);
    @(negedge clk);
    bus.muldivresp_val = 1'b0;
    check_output("bp_val2",  64'(bus.wb_val), 64'd1);
    check_output("bp_tag2",  64'(bus.wb_tag), 64'd2);
    check_output("bp_data2", 64'(bus.wb_data), 64'hb2);
    @(negedge clk);
    check_output("bp_drain", 64'(bus.wb_val), 64'd0);

    // Response with nothing in flight, then async reset mid-operation
    send_resp(64'h1234_5678);
    check_output("err_proto", 64'(bus.proto_err), 64'd1);
    check_output("err_wb_val", 64'(bus.wb_val), 64'd0);
    check_output("err_count", 64'(bus.inflight_count), 64'd0);
    bus.wb_rdy = 1'b0;
    issue_op(3'd0, 32'd1, 32'd1, 5'd9, 1'b0);
    issue_op(3'd0, 32'd2, 32'd2, 5'd10, 1'b0);
    send_resp(64'h0_00000077);
    check_output("err_pre_val", 64'(bus.wb_val), 64'd1);
    check_output("err_sticky", 64'(bus.proto_err), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_output("arst_proto",  64'(bus.proto_err), 64'd0);
    check_output("arst_count",  64'(bus.inflight_count), 64'd0);
    check_output("arst_wb_val", 64'(bus.wb_val), 64'd0);
    check_output("arst_wb_tag", 64'(bus.wb_tag), 64'd0);
    @(negedge clk);
    reset      = 1'b0;
    bus.wb_rdy = 1'b1;
    @(negedge clk);

    // Random source/sink delays over the vector table
    idx = 0;
    got = 0;
    for (int cyc = 0; cyc < 3000 && got < 12; cyc++) begin
      if (!bus.issue_val && idx < 12 && $urandom_range(0, 2) != 0) begin
        bus.issue_val = 1'b1;
        bus.issue_fn  = vecs[idx].fn;
        bus.issue_a   = vecs[idx].a;
        bus.issue_b   = vecs[idx].b;
        bus.issue_tag = vecs[idx].tag;
      end
      if (!bus.muldivresp_val && respq.size() > 0 && $urandom_range(0, 2) != 0) begin
        bus.muldivresp_val        = 1'b1;
        bus.muldivresp_msg_result = respq[0];
      end
      bus.muldivreq_rdy = ($urandom_range(0, 3) != 0);
      bus.wb_rdy        = ($urandom_range(0, 2) != 0);
      #1;
      ifire = bus.issue_val && bus.issue_rdy;
      rfire = bus.muldivresp_val && bus.muldivresp_rdy;
      if (ifire) begin
        respq.push_back(vecs[idx].resp);
        expq.push_back({vecs[idx].tag, vecs[idx].exp});
        idx++;
      end
      if (rfire) void'(respq.pop_front());
      if (bus.wb_val && bus.wb_rdy) begin
        if (expq.size() == 0) begin
          check_output("rand_unexpected_wb", 64'(bus.wb_tag), 64'hffff);
        end else begin
          e = expq.pop_front();
          check_output("rand_wb_tag",  64'(bus.wb_tag), 64'(e[36:32]));
          check_output("rand_wb_data", 64'(bus.wb_data), 64'(e[31:0]));
        end
        got++;
      end
      @(negedge clk);
      if (ifire) bus.issue_val = 1'b0;
      if (rfire) bus.muldivresp_val = 1'b0;
    end
    check_output("rand_all_done", 64'(got), 64'd12);
    bus.wb_rdy        = 1'b1;
    bus.muldivreq_rdy = 1'b1;
    @(negedge clk);
    check_output("rand_proto", 64'(bus.proto_err), 64'd0);
    check_output("rand_count", 64'(bus.inflight_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
